// File: rtl/axis_tag_demux.sv
// axis_tag_demux: routes the tagged, merged stream from the two-input
// AXI-Stream arbiter back to one of two master ports (m0a / m0b).
// The route is locked on the first beat of a packet and held until tlast.
// Beats with an invalid first-beat tag are dropped.
// Both ports share one 2-entry output skid, so output order follows input order.
// The outputs are driven from registers.
// Per-port completed-packet counters and sticky error flags are provided.
// Optional feature: define AXIS_DEMUX_LEN_CHECK_EN to enable packet length
// limiting to MAX_BEATS.
module axis_tag_demux #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 256
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_a,
  input  logic              s_axis_b,
  output logic [DATA_W-1:0] m0a_axis_tdata,
  output logic              m0a_axis_tvalid,
  input  logic              m0a_axis_tready,
  output logic              m0a_axis_tlast,
  output logic [DATA_W-1:0] m0b_axis_tdata,
  output logic              m0b_axis_tvalid,
  input  logic              m0b_axis_tready,
  output logic              m0b_axis_tlast,
  output logic [CNT_W-1:0]  pkt_count_a,
  output logic [CNT_W-1:0]  pkt_count_b,
  output logic              err_tag,
  output logic              err_len
);

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B, DROP} state_t;

  state_t              state_q, state_d;
  logic                tready_q, tready_d;
  // Head entry drives the outputs. A separate valid bit is kept per port.
  logic                head_va_q, head_va_d;
  logic                head_vb_q, head_vb_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic                head_last_q, head_last_d;
  // The second entry catches one beat while the head is stalled.
  logic                skid_v_q, skid_v_d;
  logic                skid_b_q, skid_b_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
  logic                err_tag_q, err_tag_d;

  logic accept;
  logic tag_a_only;
  logic tag_b_only;
  logic push;
  logic push_b;
  logic push_last;
  logic pop;

  assign accept     = s_axis_tvalid & tready_q;
  assign tag_a_only = s_axis_a & ~s_axis_b;
  assign tag_b_only = s_axis_b & ~s_axis_a;
  assign pop        = (head_va_q & m0a_axis_tready) | (head_vb_q & m0b_axis_tready);

`ifdef AXIS_DEMUX_LEN_CHECK_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              err_len_q, err_len_d;
  logic              at_limit;

  // The beat at the limit is truncated only if it is not already the real tlast.
  assign at_limit = (beats_q == BEAT_W'(MAX_BEATS - 1)) & ~s_axis_tlast;
`endif

  // Routing FSM next state, tag error detection, and the routing decision
  // for the beat that is being accepted.
  always_comb begin
    state_d   = state_q;
    err_tag_d = err_tag_q;
    push      = 1'b0;
    push_b    = 1'b0;
    push_last = s_axis_tlast;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (tag_a_only) begin
            push    = 1'b1;
            state_d = s_axis_tlast ? IDLE : ROUTE_A;
          end else if (tag_b_only) begin
            push    = 1'b1;
            push_b  = 1'b1;
            state_d = s_axis_tlast ? IDLE : ROUTE_B;
          end else begin
            err_tag_d = 1'b1;
            state_d   = s_axis_tlast ? IDLE : DROP;
          end
        end
        ROUTE_A: begin
          push = 1'b1;
          if (!tag_a_only) err_tag_d = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
        ROUTE_B: begin
          push   = 1'b1;
          push_b = 1'b1;
          if (!tag_b_only) err_tag_d = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
        default: begin
          if (s_axis_tlast) state_d = IDLE;
        end
      endcase
`ifdef AXIS_DEMUX_LEN_CHECK_EN
      if (push && at_limit) begin
        push_last = 1'b1;
        state_d   = DROP;
      end
`endif
    end
  end

`ifdef AXIS_DEMUX_LEN_CHECK_EN
  // Beat counter for the current packet. It restarts whenever the packet
  // ends or the beat stream is being discarded.
  always_comb begin
    beats_d   = beats_q;
    err_len_d = err_len_q;
    if (accept) begin
      if (state_d == IDLE || state_d == DROP) beats_d = '0;
      else                                    beats_d = beats_q + BEAT_W'(1);
      if (push && at_limit) err_len_d = 1'b1;
    end
  end

  // Length-check state.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      beats_q   <= '0;
      err_len_q <= 1'b0;
    end else begin
      beats_q   <= beats_d;
      err_len_q <= err_len_d;
    end
  end

  assign err_len = err_len_q;
`else
  // Length checking is compiled out, so MAX_BEATS has no effect and err_len is always 0.
  assign err_len = 1'b0 & (MAX_BEATS == 0);
`endif

  // Shared 2-entry skid. First retire the head (and promote the skid entry),
  // then place the new beat in the first free slot.
  always_comb begin
    head_va_d   = head_va_q;
    head_vb_d   = head_vb_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_v_d    = skid_v_q;
    skid_b_d    = skid_b_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (pop) begin
      head_va_d   = skid_v_q & ~skid_b_q;
      head_vb_d   = skid_v_q & skid_b_q;
      head_data_d = skid_data_q;
      head_last_d = skid_last_q;
      skid_v_d    = 1'b0;
    end
    if (push) begin
      if (!(head_va_d | head_vb_d)) begin
        head_va_d   = ~push_b;
        head_vb_d   = push_b;
        head_data_d = s_axis_tdata;
        head_last_d = push_last;
      end else begin
        skid_v_d    = 1'b1;
        skid_b_d    = push_b;
        skid_data_d = s_axis_tdata;
        skid_last_d = push_last;
      end
    end
  end

  // Input ready and per-port packet counters.
  // In DROP, beats are discarded and use no buffer space,
  // so the input is not backpressured.
  always_comb begin
    tready_d = ~skid_v_d | (state_d == DROP);
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    if (head_va_q && m0a_axis_tready && head_last_q) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (head_vb_q && m0b_axis_tready && head_last_q) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  // All state registers. The reset clears every output.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      head_va_q   <= 1'b0;
      head_vb_q   <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_b_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      err_tag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      head_va_q   <= head_va_d;
      head_vb_q   <= head_vb_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_v_q    <= skid_v_d;
      skid_b_q    <= skid_b_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      err_tag_q   <= err_tag_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign m0a_axis_tvalid = head_va_q;
  assign m0a_axis_tdata  = head_data_q;
  assign m0a_axis_tlast  = head_last_q;
  assign m0b_axis_tvalid = head_vb_q;
  assign m0b_axis_tdata  = head_data_q;
  assign m0b_axis_tlast  = head_last_q;
  assign pkt_count_a     = cnt_a_q;
  assign pkt_count_b     = cnt_b_q;
  assign err_tag         = err_tag_q;

endmodule

// File: tb/tb_axis_tag_demux.sv
// Testbench for axis_tag_demux.
// A packet-level reference model (one expected-beat queue per port) is
// checked on every clock cycle. Hand-computed literals after each scenario
// pin the model itself.
// When AXIS_DEMUX_LEN_CHECK_EN is defined, the DUT is built with MAX_BEATS=8.
module tb_axis_tag_demux;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef AXIS_DEMUX_LEN_CHECK_EN
  localparam int MAXB   = 8;
  localparam bit LEN_EN = 1'b1;
`else
  localparam int MAXB   = 256;
  localparam bit LEN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_a = 1'b0;
  logic          s_b = 1'b0;
  logic [DW-1:0] m0a_tdata, m0b_tdata;
  logic          m0a_tvalid, m0b_tvalid, m0a_tlast, m0b_tlast;
  logic          m0a_tready, m0b_tready;
  logic [CW-1:0] pkt_count_a, pkt_count_b;
  logic          err_tag, err_len;

  logic          a_rdy = 1'b0;
  logic          b_rdy = 1'b0;
  logic          lfsr_en = 1'b0;
  logic [15:0]   lfsr = 16'hACE1;

  assign m0a_tready = a_rdy;
  assign m0b_tready = lfsr_en ? lfsr[0] : b_rdy;

  always #5 clk = ~clk;

  axis_tag_demux #(.DATA_W(DW), .CNT_W(CW), .MAX_BEATS(MAXB)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_a(s_a), .s_axis_b(s_b),
    .m0a_axis_tdata(m0a_tdata), .m0a_axis_tvalid(m0a_tvalid),
    .m0a_axis_tready(m0a_tready), .m0a_axis_tlast(m0a_tlast),
    .m0b_axis_tdata(m0b_tdata), .m0b_axis_tvalid(m0b_tvalid),
    .m0b_axis_tready(m0b_tready), .m0b_axis_tlast(m0b_tlast),
    .pkt_count_a(pkt_count_a), .pkt_count_b(pkt_count_b),
    .err_tag(err_tag), .err_len(err_len)
  );

  // Pseudorandom ready pattern for port b.
  always begin
    @(posedge clk);
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t   qa[$];
  beat_t   qb[$];
  int      exp_cnt_a = 0;
  int      exp_cnt_b = 0;
  bit      exp_err_tag = 1'b0;
  bit      exp_err_len = 1'b0;
  bit      in_pkt = 1'b0;
  int      dest = 0;      // 0: port a, 1: port b, 2: discard
  int      nbeat = 0;
  bit      pend_a = 1'b0;
  bit      pend_b = 1'b0;
  int      cyc = 0;
  int      first_acc = -1;
  int      first_va = -1;
  logic [DW-1:0] last_a_data = '0;
  int      compared = 0;
  int      mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare.
  // Each iteration first checks the outputs, then applies the handshakes
  // that will complete on the next rising edge.
  always @(negedge clk) begin
    int    occ;
    beat_t nb;
    bit    trunc;
    cyc++;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      exp_cnt_a   = 0;
      exp_cnt_b   = 0;
      exp_err_tag = 1'b0;
      exp_err_len = 1'b0;
      in_pkt      = 1'b0;
      pend_a      = 1'b0;
      pend_b      = 1'b0;
    end else begin
      chk("pkt_count_a", pkt_count_a, exp_cnt_a[CW-1:0]);
      chk("pkt_count_b", pkt_count_b, exp_cnt_b[CW-1:0]);
      chk("err_tag", err_tag, exp_err_tag);
      chk("err_len", err_len, exp_err_len);
      chk("both_valid", m0a_tvalid & m0b_tvalid, 0);
      occ = qa.size() + qb.size();
      chk("occupancy_le2", occ > 2, 0);
      if (!(in_pkt && dest == 2)) chk("s_tready", s_tready, occ < 2);
      if (pend_a) chk("a_valid_withdrawn", m0a_tvalid, 1);
      if (pend_b) chk("b_valid_withdrawn", m0b_tvalid, 1);
      if (m0a_tvalid) begin
        if (first_va < 0) first_va = cyc;
        if (qa.size() == 0) chk("a_unexpected_valid", m0a_tvalid, 0);
        else begin
          chk("a_data", m0a_tdata, qa[0].d);
          chk("a_last", m0a_tlast, qa[0].l);
          if (m0a_tready) begin
            if (qa[0].l) begin
              exp_cnt_a++;
              last_a_data = qa[0].d;
            end
            void'(qa.pop_front());
          end
        end
      end
      if (m0b_tvalid) begin
        if (qb.size() == 0) chk("b_unexpected_valid", m0b_tvalid, 0);
        else begin
          chk("b_data", m0b_tdata, qb[0].d);
          chk("b_last", m0b_tlast, qb[0].l);
          if (m0b_tready) begin
            if (qb[0].l) exp_cnt_b++;
            void'(qb.pop_front());
          end
        end
      end
      pend_a = m0a_tvalid & ~m0a_tready;
      pend_b = m0b_tvalid & ~m0b_tready;
      if (s_tvalid && s_tready) begin
        if (first_acc < 0) first_acc = cyc;
        if (!in_pkt) begin
          if (s_a && !s_b)      dest = 0;
          else if (s_b && !s_a) dest = 1;
          else begin
            dest = 2;
            exp_err_tag = 1'b1;
          end
          nbeat  = 0;
          in_pkt = 1'b1;
        end else if (dest == 0 && !(s_a && !s_b)) exp_err_tag = 1'b1;
        else if (dest == 1 && !(s_b && !s_a))     exp_err_tag = 1'b1;
        nbeat++;
        if (dest != 2) begin
          trunc = LEN_EN && (nbeat == MAXB) && !s_tlast;
          nb.d  = s_tdata;
          nb.l  = s_tlast | trunc;
          if (dest == 0) qa.push_back(nb);
          else           qb.push_back(nb);
          if (trunc) begin
            exp_err_len = 1'b1;
            dest = 2;
          end
        end
        if (s_tlast) in_pkt = 1'b0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet. The caller must be at posedge+1.
  // bad_idx selects the beat (1-based) that carries bad_tag {a,b} instead of
  // the packet tag.
  task automatic send_pkt(input bit ta, input bit tb_, input int n, input int base,
                          input int bad_idx, input logic [1:0] bad_tag, output int stalls);
    bit hs;
    int guard;
    stalls = 0;
    for (int i = 1; i <= n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(base + i - 1);
      s_tlast  = (i == n);
      if (i == bad_idx) {s_a, s_b} = bad_tag;
      else              {s_a, s_b} = {ta, tb_};
      guard = 0;
      hs    = 1'b0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        hs = s_tready;
        @(posedge clk);
        #1;
        if (!hs) stalls++;
        guard++;
      end
      if (!hs) chk("send_timeout", s_tready, 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((qa.size() + qb.size()) != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if ((qa.size() + qb.size()) != 0) chk("drain_timeout", 64'(qa.size() + qb.size()), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int st, st_sum;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st_sum;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", s_tready, 0);
    chk("rst_a_valid", m0a_tvalid, 0);
    chk("rst_b_valid", m0b_tvalid, 0);
    chk("rst_a_data", m0a_tdata, 0);
    chk("rst_cnt_a", pkt_count_a, 0);
    chk("rst_err_tag", err_tag, 0);
    a_rdy = 1'b1;
    b_rdy = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_release", s_tready, 1);

    // 1: 31-beat packet tagged a, data 1..31
    sync();
    send_pkt(1'b1, 1'b0, 31, 1, 0, 2'b00, st);
    drain();
    $display("T1 a31: cnt_a=%0d cnt_b=%0d lat=%0d", pkt_count_a, pkt_count_b, first_va - first_acc);
    chk("t1_cnt_a", pkt_count_a, 1);
    chk("t1_cnt_b", pkt_count_b, 0);
    chk("t1_latency", 64'(first_va - first_acc), 1);
    chk("t1_last_data", last_a_data, LEN_EN ? 8 : 31);

    // 2: back-to-back a4, b3, a1
    sync();
    send_pkt(1'b1, 1'b0, 4, 100, 0, 2'b00, st);
    st_sum = st;
    send_pkt(1'b0, 1'b1, 3, 200, 0, 2'b00, st);
    st_sum += st;
    send_pkt(1'b1, 1'b0, 1, 300, 0, 2'b00, st);
    st_sum += st;
    drain();
    $display("T2 a4/b3/a1: cnt_a=%0d cnt_b=%0d stalls=%0d", pkt_count_a, pkt_count_b, st_sum);
    chk("t2_cnt_a", pkt_count_a, 3);
    chk("t2_cnt_b", pkt_count_b, 1);
    chk("t2_no_stall", 64'(st_sum), 0);
    chk("t2_last_a", last_a_data, 300);
    chk("t2_err_tag", err_tag, 0);

    // 3: 31-beat packet tagged b while port b ready follows the LFSR
    sync();
    lfsr_en = 1'b1;
    send_pkt(1'b0, 1'b1, 31, 1000, 0, 2'b00, st);
    lfsr_en = 1'b0;
    drain();
    $display("T3 b31 lfsr: cnt_b=%0d stalls=%0d", pkt_count_b, st);
    chk("t3_cnt_b", pkt_count_b, 2);
    chk("t3_backpressure_seen", 64'(st > 0), 1);

    // 4: {1,1} packet of 5 beats, then a 2-beat b packet
    sync();
    send_pkt(1'b1, 1'b1, 5, 2000, 0, 2'b00, st);
    send_pkt(1'b0, 1'b1, 2, 2100, 0, 2'b00, st);
    drain();
    $display("T4 drop5+b2: cnt_a=%0d cnt_b=%0d err_tag=%0d", pkt_count_a, pkt_count_b, err_tag);
    chk("t4_err_tag", err_tag, 1);
    chk("t4_cnt_b", pkt_count_b, 3);
    chk("t4_cnt_a", pkt_count_a, 3);

    // Reset asserted mid-packet while port a is stalled
    sync();
    a_rdy    = 1'b0;
    s_tvalid = 1'b1;
    s_a      = 1'b1;
    s_b      = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 5000;
    repeat (4) sync();
    chk("mid_tready_low", s_tready, 0);
    #2 rst_n = 1'b0;
    #1;
    $display("RST mid-packet: tready=%0d a_valid=%0d cnt_a=%0d", s_tready, m0a_tvalid, pkt_count_a);
    chk("mid_rst_tready", s_tready, 0);
    chk("mid_rst_a_valid", m0a_tvalid, 0);
    chk("mid_rst_a_data", m0a_tdata, 0);
    chk("mid_rst_a_last", m0a_tlast, 0);
    chk("mid_rst_b_valid", m0b_tvalid, 0);
    chk("mid_rst_cnt_a", pkt_count_a, 0);
    chk("mid_rst_cnt_b", pkt_count_b, 0);
    chk("mid_rst_err_tag", err_tag, 0);
    chk("mid_rst_err_len", err_len, 0);
    s_tvalid = 1'b0;
    a_rdy    = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_tready_after_release", s_tready, 1);

    // 5: packet locked to a, beat 3 tagged b
    sync();
    send_pkt(1'b1, 1'b0, 6, 3000, 3, 2'b01, st);
    drain();
    $display("T5 a6 bad tag: cnt_a=%0d cnt_b=%0d err_tag=%0d", pkt_count_a, pkt_count_b, err_tag);
    chk("t5_cnt_a", pkt_count_a, 1);
    chk("t5_cnt_b", pkt_count_b, 0);
    chk("t5_err_tag", err_tag, 1);
    chk("t5_last_a", last_a_data, 3005);
    chk("t5_err_len", err_len, 0);

`ifdef AXIS_DEMUX_LEN_CHECK_EN
    // 6: 12-beat packet tagged a, truncated at 8 beats
    sync();
    send_pkt(1'b1, 1'b0, 12, 4000, 0, 2'b00, st);
    drain();
    $display("T6 a12 len: cnt_a=%0d err_len=%0d last=%0d", pkt_count_a, err_len, last_a_data);
    chk("t6_cnt_a", pkt_count_a, 2);
    chk("t6_err_len", err_len, 1);
    chk("t6_last_a", last_a_data, 4007);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axis_tag_demux.md
Name: axis_tag_demux

Overview:
Downstream companion to the two-input AXI-Stream arbiter. It consumes the arbiter's merged m0k stream plus its one-hot source tags (a/b) and routes each packet back out to one of two AXI-Stream master ports, m0a or m0b. Packet boundaries are respected: the route is locked on the first beat and held until tlast. Output is fully registered, with a 2-entry skid buffer, and per-port packet counters are provided.

Parameters:
DATA_W, 32, tdata width in bits
CNT_W, 16, width of per-port completed-packet counters
MAX_BEATS, 256, max beats per packet (used only with the optional feature)

Ports:
axis_aclk  in  1  clock
axis_aresetn  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  DATA_W  merged stream data from arbiter m0k
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
s_axis_a  in  1  tag: beat originated from source a
s_axis_b  in  1  tag: beat originated from source b
m0a_axis_tdata  out  DATA_W  port a data
m0a_axis_tvalid  out  1  port a valid
m0a_axis_tready  in  1  port a ready
m0a_axis_tlast  out  1  port a last
m0b_axis_tdata  out  DATA_W  port b data
m0b_axis_tvalid  out  1  port b valid
m0b_axis_tready  in  1  port b ready
m0b_axis_tlast  out  1  port b last
pkt_count_a  out  CNT_W  packets completed on m0a
pkt_count_b  out  CNT_W  packets completed on m0b
err_tag  out  1  sticky: tag error seen
err_len  out  1  sticky: over-length packet (optional feature)

Behaviour:
- Reset (async, axis_aresetn=0) clears every output to 0: s_axis_tready, all m0*_tvalid/tdata/tlast, counters, err_tag, err_len. State goes to IDLE and the skid buffer is emptied. s_axis_tready rises on the first clock edge after reset release.
- Input handshake: a beat is accepted on a rising edge when s_axis_tvalid and s_axis_tready are both 1.
- s_axis_tready is registered and equals NOT(skid full).
- Output stage is a 2-entry skid buffer, one shared for both ports (not two separate buffers). Latency from accepting a beat to valid on its output is 1 cycle.
- Only the selected port's tvalid may be 1; the other port's tvalid is 0.
- Once tvalid is asserted, tdata and tlast stay stable until tready; the beat is not withdrawn.
- With the selected port's tready held at 1, throughput is 1 beat/cycle.
- FSM states: IDLE, ROUTE_A, ROUTE_B, DROP.
- IDLE, on an accepted beat, by tag {a,b}:
  - {1,0}: go to ROUTE_A.
  - {0,1}: go to ROUTE_B.
  - {1,1} or {0,0}: go to DROP and set err_tag.
  - The beat itself goes to the chosen port, or is discarded in DROP.
  - If that first beat also has tlast=1 (single-beat packet), deliver it and stay in IDLE.
- ROUTE_A / ROUTE_B: every accepted beat goes to the locked port regardless of its tag. If a tag disagrees with the lock, set err_tag and keep routing. The beat with tlast=1 returns the FSM to IDLE.
- DROP: accept and discard beats with s_axis_tready=1 (no backpressure); tlast returns to IDLE.
- pkt_count_x increments by 1 when a tlast beat completes its handshake on m0x. It wraps modulo 2^CNT_W.
- err_tag and err_len clear only on reset.
- Backpressure: if the locked port's tready is 0, the skid fills and s_axis_tready drops on the following cycle. No beat is lost or duplicated.
- The next packet may start on the cycle after tlast is accepted. Its first beat may target the other port while the previous packet's final beats are still in the skid; output order is preserved.
- Reset asserted mid-packet: any partially delivered packet is abandoned; after release the FSM is in IDLE.

Optional Feature:
- Macro AXIS_DEMUX_LEN_CHECK_EN.
- When defined:
  - A beat counter runs per packet.
  - If beat MAX_BEATS is not tlast, it is output with tlast forced to 1, err_len is set, and the FSM enters DROP until the input tlast.
  - pkt_count counts the truncated packet.
- When undefined: no beat counter, MAX_BEATS ignored, err_len tied to 0, packets of any length are passed.

Test Plan:
- Reset, then a 31-beat packet tagged a (data 1..31, last on 31), both treadys at 1 -> m0a receives 1..31 with tlast on 31, m0b_tvalid stays 0, pkt_count_a=1, first m0a_tvalid 1 cycle after first accept.
- Alternate packets a (4 beats), b (3 beats), a (1 beat, tlast) back-to-back -> each port sees its beats in order, pkt_count_a=2, pkt_count_b=1, no idle cycle on input.
- m0b_tready driven by an LFSR pseudorandom pattern during a 31-beat b packet -> all 31 beats on m0b in order, no duplicates, s_axis_tready low within 1 cycle of skid full.
- First beat tagged {1,1}, 5-beat packet, then a 2-beat b packet -> 5 beats discarded, err_tag=1, b packet delivered intact, pkt_count_b=1.
- Packet locked to a with beat 3 tagged b -> all beats on m0a, err_tag=1.
- With AXIS_DEMUX_LEN_CHECK_EN and MAX_BEATS=8, a 12-beat packet a -> m0a gets 8 beats with tlast on beat 8, err_len=1, beats 9..12 dropped. Assert reset mid-packet -> all outputs 0 immediately.
